// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte bundle from uart_rx to the command parser
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output r_data,
        output r_valid,
        output frame_err,
        output busy
    );

    modport slave (
        input r_data,
        input r_valid,
        input frame_err,
        input busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and framing-error detection
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       s_tick,
    input  logic       rxd,
    uart_rx_if.master  rx
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state;
    logic                 rxd_m;
    logic                 rxd_s;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] sh;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 frame_err;
    logic                 busy;

    // Sync FFs reset high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (tick_cnt == TICK_HALF) begin
                            tick_cnt <= '0;
                            if (!rxd_s) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            sh       <= {rxd_s, sh[DATA_BITS-1:1]};
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (rxd_s) begin
                                r_data  <= sh;
                                r_valid <= 1'b1;
                                busy    <= 1'b0;
                                state   <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    // Wait out a held-low line so it cannot start a bogus frame.
                    if (rxd_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx.r_data    = r_data;
    assign rx.r_valid   = r_valid;
    assign rx.frame_err = frame_err;
    assign rx.busy      = busy;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed table-driven bench for uart_rx
module tb_uart_rx;
    logic clk;
    logic n_rst;
    logic s_tick;
    logic rxd;

    uart_rx_if #(.DATA_BITS(8)) rx_if ();

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .s_tick (s_tick),
        .rxd    (rxd),
        .rx     (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tick_num = 0;
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            tick_num = tick_num + 1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    int         vcnt = 0;
    int         fcnt = 0;
    int         both_seen = 0;
    logic [7:0] vdata_last = 8'h00;
    logic [7:0] vdata_prev = 8'h00;
    int         vtick_last = 0;
    int         vtick_prev = 0;

    always @(negedge clk) begin
        if (rx_if.r_valid) begin
            vcnt       = vcnt + 1;
            vdata_prev = vdata_last;
            vdata_last = rx_if.r_data;
            vtick_prev = vtick_last;
            vtick_last = tick_num;
        end
        if (rx_if.frame_err) fcnt = fcnt + 1;
        if (rx_if.r_valid && rx_if.frame_err) both_seen = both_seen + 1;
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act == exp) passes = passes + 1;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_bit(input logic v, input int ticks);
        rxd = v;
        repeat (ticks * 4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_ticks);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
        drive_bit(stop, stop_ticks);
        rxd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         stop_ticks;
        int         exp_v;
        int         exp_f;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int v0;
        int f0;
        vecs[0] = '{8'h55, 1'b1, 16, 1, 0, 8'h55};
        vecs[1] = '{8'h3C, 1'b0, 40, 0, 1, 8'h55};
        vecs[2] = '{8'h81, 1'b1, 16, 1, 0, 8'h81};
        vecs[3] = '{8'hFF, 1'b1, 16, 1, 0, 8'hFF};

        rxd   = 1'b1;
        n_rst = 1'b0;
        repeat (4) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("reset_r_data", int'(rx_if.r_data), 0);
        check("reset_r_valid", int'(rx_if.r_valid), 0);
        check("reset_frame_err", int'(rx_if.frame_err), 0);
        check("reset_busy", int'(rx_if.busy), 0);
        drive_bit(1'b1, 20);

        for (int i = 0; i < 4; i++) begin
            v0 = vcnt;
            f0 = fcnt;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].stop_ticks);
            drive_bit(1'b1, 32);
            check($sformatf("vec%0d_valid_cnt", i), vcnt - v0, vecs[i].exp_v);
            check($sformatf("vec%0d_ferr_cnt", i), fcnt - f0, vecs[i].exp_f);
            check($sformatf("vec%0d_r_data", i), int'(rx_if.r_data), int'(vecs[i].exp_d));
            check($sformatf("vec%0d_busy", i), int'(rx_if.busy), 0);
        end

        // Back-to-back frames with no idle gap between stop and next start.
        v0 = vcnt;
        f0 = fcnt;
        send_frame(8'hA3, 1'b1, 16);
        send_frame(8'h00, 1'b1, 16);
        drive_bit(1'b1, 32);
        check("b2b_valid_cnt", vcnt - v0, 2);
        check("b2b_ferr_cnt", fcnt - f0, 0);
        check("b2b_first", int'(vdata_prev), 8'hA3);
        check("b2b_second", int'(vdata_last), 8'h00);
        check("b2b_gap_ok", int'((vtick_last - vtick_prev) >= 159 && (vtick_last - vtick_prev) <= 161), 1);

        v0 = vcnt;
        send_frame(8'hFF, 1'b1, 16);
        drive_bit(1'b1, 32);
        check("ff_valid_cnt", vcnt - v0, 1);
        check("ff_r_data", int'(rx_if.r_data), 8'hFF);

        // Short low pulse: start bit rejected at mid-bit.
        v0 = vcnt;
        f0 = fcnt;
        drive_bit(1'b0, 4);
        check("glitch_busy_high", int'(rx_if.busy), 1);
        drive_bit(1'b1, 8);
        check("glitch_busy_low", int'(rx_if.busy), 0);
        drive_bit(1'b1, 200);
        check("glitch_no_valid", vcnt - v0, 0);
        check("glitch_no_ferr", fcnt - f0, 0);

        // Reset in the middle of data bit 4.
        v0 = vcnt;
        f0 = fcnt;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 8);
        check("pre_reset_busy", int'(rx_if.busy), 1);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        check("midrst_r_data", int'(rx_if.r_data), 0);
        check("midrst_r_valid", int'(rx_if.r_valid), 0);
        check("midrst_frame_err", int'(rx_if.frame_err), 0);
        check("midrst_busy", int'(rx_if.busy), 0);
        drive_bit(1'b1, 200);
        check("midrst_no_valid", vcnt - v0, 0);
        check("midrst_no_ferr", fcnt - f0, 0);

        v0 = vcnt;
        send_frame(8'h7E, 1'b1, 16);
        drive_bit(1'b1, 32);
        check("post_rst_valid_cnt", vcnt - v0, 1);
        check("post_rst_r_data", int'(rx_if.r_data), 8'h7E);

        check("valid_ferr_exclusive", both_seen, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the calculator's UART link. It recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from the serial input `rxd` using a 16x-oversampling tick from the shared baud generator. It presents each byte to the command parser with a one-cycle valid strobe. It reports framing errors and does not forward bad frames.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: `s_tick` pulses per bit period. Must be even and ≥ 4.
- `DATA_BITS`, default 8: data bits per frame.

Ports:
- `clk`, input, 1: system clock; all logic on rising edge.
- `n_rst`, input, 1: reset, synchronous, active-low; sampled on rising `clk`.
- `s_tick`, input, 1: one-`clk` pulse at OVERSAMPLE × baud rate, from the baud generator.
- `rxd`, input, 1: asynchronous serial line; idle high.
- `r_data`, output, DATA_BITS: last correctly framed byte.
- `r_valid`, output, 1: one-cycle strobe when `r_data` updates.
- `frame_err`, output, 1: one-cycle strobe when the stop bit samples low.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- Input sync: `rxd` passes through a 2-FF synchronizer. Both FFs reset to 1. All decisions use the synchronized copy `rxd_s`.
- Counters:
  - `tick_cnt` has width clog2(OVERSAMPLE) and advances only on cycles where `s_tick` = 1.
  - `bit_cnt` has width clog2(DATA_BITS+1).
  - Shift register `sh` is DATA_BITS wide and shifts right; each new bit enters at the MSB.
- States: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rxd_s` = 0, go to START with `tick_cnt` = 0. No tick is needed.
  - START: on each `s_tick`, increment `tick_cnt`. At the tick where `tick_cnt` = OVERSAMPLE/2−1 (the mid start bit):
    - if `rxd_s` = 0, go to DATA with `tick_cnt` = 0 and `bit_cnt` = 0;
    - otherwise treat it as a glitch and return to IDLE.
  - DATA: at the tick where `tick_cnt` = OVERSAMPLE−1, shift in `rxd_s`, set `tick_cnt` to 0 and increment `bit_cnt`. After the DATA_BITS-th sample, go to STOP.
  - STOP: at the tick where `tick_cnt` = OVERSAMPLE−1 (mid stop bit):
    - if `rxd_s` = 1, load `r_data` ← `sh`, pulse `r_valid`, go to IDLE;
    - if `rxd_s` = 0, pulse `frame_err`, leave `r_data` unchanged, go to BREAK.
  - BREAK: stay until `rxd_s` = 1, then go to IDLE. This prevents a held-low line from retriggering reception.
- `r_data` holds its value until the next good frame. There is no buffering: the consumer must capture `r_data` on `r_valid`. A new frame can begin immediately after STOP, so back-to-back frames are supported.
- Reset at any point, including mid-frame, aborts reception. The partial byte is discarded and no strobe is issued.

## Timing
- Reset values: `r_data` = 0, `r_valid` = 0, `frame_err` = 0, `busy` = 0, state = IDLE, counters = 0, `sh` = 0, sync FFs = 1.
- Outputs are registered. `r_valid` / `frame_err` are high for exactly the one `clk` cycle following the mid-stop-bit tick edge.
- Latency from the start-bit falling edge on `rxd` to `r_valid`:
  - 2 `clk` cycles (synchronizer), plus
  - (OVERSAMPLE/2 + DATA_BITS·OVERSAMPLE + OVERSAMPLE) ticks (±1 tick of phase), plus
  - 1 `clk` cycle.
- `busy` rises 1 cycle after `rxd_s` falls. It falls in the same cycle that `r_valid` rises, or when BREAK exits.
- Counter state changes only on `s_tick` cycles, except the IDLE→START and BREAK→IDLE transitions, which are evaluated every `clk`.
- `r_valid` and `frame_err` are never high in the same cycle.

## Test plan
- Single frame 0x55: `s_tick` every 4 `clk`, 16 ticks/bit, stop bit = 1 → one `r_valid` pulse with `r_data` = 0x55, `frame_err` = 0, `busy` low afterwards.
- Back-to-back frames 0xA3 then 0x00 with no idle gap → two `r_valid` pulses, 160 ticks apart ±1, carrying 0xA3 then 0x00. Then 0xFF → `r_data` = 0xFF.
- Glitch: `rxd` low for 4 ticks, then high → START aborts to IDLE, no `r_valid`, no `frame_err`, `busy` drops within OVERSAMPLE/2 ticks.
- Framing error: frame 0x3C with stop bit = 0, line held low for 40 ticks, then high → exactly one `frame_err` pulse, `r_data` keeps its previous value, no retrigger while low. A subsequent valid 0x81 → `r_data` = 0x81.
- Reset mid-frame: assert `n_rst` = 0 for 1 cycle during data bit 4 → all outputs at reset values on the next cycle, no strobe for that frame. The next full frame 0x7E is received correctly.
